mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (CPU / debug loader) arbiter in front of a single-port block RAM.
// Round-robin on contention, with a bounded debug burst lock and per-requester read return.
//
// state  | meaning (grant issued in the previous cycle)
// -------+---------------------------------------------
// S_IDLE | no grant
// S_CPU  | CPU granted
// S_DBG  | debug granted, unlocked
// S_LOCK | debug granted under dbg_lock
module mem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAX_LOCK = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic          dbg_lock,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK);

    typedef enum logic [1:0] {S_IDLE, S_CPU, S_DBG, S_LOCK} state_t;

    state_t        state, state_nxt;
    logic          last, last_nxt;          // 1: debug was granted most recently
    logic [CW-1:0] lock_cnt, lock_cnt_nxt;
    logic [DW-1:0] cpu_rdata_q, dbg_rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            last     <= 1'b1;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    always_comb begin
        cpu_gnt      = 1'b0;
        dbg_gnt      = 1'b0;
        state_nxt    = S_IDLE;
        last_nxt     = last;
        lock_cnt_nxt = '0;
        if (rst) begin
            // A held lock only yields to the CPU once the burst budget is spent.
            if (state == S_LOCK && dbg_req && dbg_lock) begin
                if (lock_cnt == CNT_MAX && cpu_req) cpu_gnt = 1'b1;
                else                                dbg_gnt = 1'b1;
            end else if (cpu_req && dbg_req) begin
                if (last) cpu_gnt = 1'b1;
                else      dbg_gnt = 1'b1;
            end else begin
                cpu_gnt = cpu_req;
                dbg_gnt = dbg_req;
            end

            if (cpu_gnt) begin
                state_nxt = S_CPU;
                last_nxt  = 1'b0;
            end else if (dbg_gnt) begin
                last_nxt = 1'b1;
                if (dbg_lock) begin
                    state_nxt = S_LOCK;
                    if (state != S_LOCK)        lock_cnt_nxt = CW'(1);
                    else if (lock_cnt == CNT_MAX) lock_cnt_nxt = lock_cnt;
                    else                        lock_cnt_nxt = lock_cnt + CW'(1);
                end else begin
                    state_nxt = S_DBG;
                end
            end
        end
    end

    always_comb begin
        mem_en    = cpu_gnt | dbg_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    // RAM data arrives the cycle after the read grant; steer it and keep a copy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rvalid  <= 1'b0;
            dbg_rvalid  <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            cpu_rvalid <= cpu_gnt & ~cpu_we;
            dbg_rvalid <= dbg_gnt & ~dbg_we;
            if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
            if (dbg_rvalid) dbg_rdata_q <= mem_rdata;
        end
    end

    assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    assign dbg_rdata = dbg_rvalid ? mem_rdata : dbg_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port RAM behind it.
// Inputs change just after the rising edge; outputs are sampled on the falling edge.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
    logic [7:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic       cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [7:0] cpu_rdata, dbg_rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic [7:0] ram [256];

    int n_run  = 0;
    int n_fail = 0;

    mem_arbiter #(.AW(8), .DW(8), .MAX_LOCK(16)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cpu(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_dbg(input logic r, input logic w, input logic l,
                           input logic [7:0] a, input logic [7:0] d);
        dbg_req = r; dbg_we = w; dbg_lock = l; dbg_addr = a; dbg_wdata = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Exclusivity and mem_en consistency on every cycle.
    always @(negedge clk) begin
        chk("excl", 32'(cpu_gnt & dbg_gnt), 32'd0);
        chk("mem_en", 32'(mem_en), 32'(cpu_gnt | dbg_gnt));
    end

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'hA5;
        rst = 1'b0;
        set_cpu(1, 0, 8'h10, 8'h00);
        set_dbg(1, 0, 0, 8'h20, 8'h00);

        // reset state with requests pending
        @(negedge clk);
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_dbg_gnt", dbg_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_rvalid", {cpu_rvalid, dbg_rvalid}, 0);
        chk("rst_rdata", {cpu_rdata, dbg_rdata}, 0);
        next_cycle();

        // tie after reset: CPU first, then debug, reads return in order
        rst = 1'b1;
        @(negedge clk);
        chk("rr0_cpu_gnt", cpu_gnt, 1);
        chk("rr0_dbg_gnt", dbg_gnt, 0);
        chk("rr0_addr", mem_addr, 8'h10);
        next_cycle();
        set_cpu(0, 0, 8'h00, 8'h00);
        @(negedge clk);
        chk("rr1_dbg_gnt", dbg_gnt, 1);
        chk("rr1_addr", mem_addr, 8'h20);
        chk("rr1_cpu_rvalid", cpu_rvalid, 1);
        chk("rr1_cpu_rdata", cpu_rdata, 8'hB5);
        next_cycle();
        set_dbg(0, 0, 0, 8'h00, 8'h00);
        @(negedge clk);
        chk("rr2_dbg_rvalid", dbg_rvalid, 1);
        chk("rr2_dbg_rdata", dbg_rdata, 8'h85);
        chk("rr2_cpu_rvalid", cpu_rvalid, 0);
        chk("rr2_cpu_hold", cpu_rdata, 8'hB5);
        next_cycle();
        @(negedge clk);
        chk("rr3_dbg_rvalid", dbg_rvalid, 0);
        chk("rr3_dbg_hold", dbg_rdata, 8'h85);
        next_cycle();

        // debug write then CPU read-back
        set_dbg(1, 1, 0, 8'h20, 8'h55);
        @(negedge clk);
        chk("wr_dbg_gnt", dbg_gnt, 1);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_wdata", mem_wdata, 8'h55);
        next_cycle();
        set_dbg(0, 0, 0, 8'h00, 8'h00);
        set_cpu(1, 0, 8'h20, 8'h00);
        @(negedge clk);
        chk("rb_cpu_gnt", cpu_gnt, 1);
        chk("rb_mem_we", mem_we, 0);
        chk("wr_no_rvalid", dbg_rvalid, 0);
        next_cycle();
        set_cpu(0, 0, 8'h00, 8'h00);
        @(negedge clk);
        chk("rb_cpu_rvalid", cpu_rvalid, 1);
        chk("rb_cpu_rdata", cpu_rdata, 8'h55);
        chk("rb_dbg_rvalid", dbg_rvalid, 0);
        next_cycle();

        // CPU alone for five cycles, reads of 0x01..0x05
        for (int k = 1; k <= 6; k++) begin
            if (k <= 5) set_cpu(1, 0, 8'(k), 8'h00);
            else        set_cpu(0, 0, 8'h00, 8'h00);
            @(negedge clk);
            chk("solo_gnt", cpu_gnt, (k <= 5));
            chk("solo_rvalid", cpu_rvalid, (k > 1));
            if (k > 1) chk("solo_rdata", cpu_rdata, 8'(k - 1) ^ 8'hA5);
            next_cycle();
        end
        @(negedge clk);
        chk("solo_rvalid_end", cpu_rvalid, 0);
        next_cycle();

        // locked debug burst against a continuous CPU request (last = CPU here)
        set_cpu(1, 0, 8'h40, 8'h00);
        set_dbg(1, 1, 1, 8'h30, 8'h77);
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            chk("lock_cpu_gnt", cpu_gnt, (i == 16 || i == 33));
            chk("lock_dbg_gnt", dbg_gnt, !(i == 16 || i == 33));
            if (i == 17) begin
                chk("lock_cpu_rvalid", cpu_rvalid, 1);
                chk("lock_cpu_rdata", cpu_rdata, 8'hE5);
            end
            if (i == 18) chk("lock_cpu_rvalid_off", cpu_rvalid, 0);
            next_cycle();
        end

        // CPU goes quiet: debug keeps the lock past the budget, counter saturates
        set_cpu(0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            chk("sat_dbg_gnt", dbg_gnt, 1);
            next_cycle();
        end
        set_cpu(1, 0, 8'h41, 8'h00);
        @(negedge clk);
        chk("sat_cpu_gnt", cpu_gnt, 1);
        next_cycle();
        @(negedge clk);
        chk("relock_dbg_gnt", dbg_gnt, 1);
        next_cycle();

        // dropping the lock returns to round-robin
        dbg_lock = 1'b0;
        @(negedge clk);
        chk("unlock_cpu_gnt", cpu_gnt, 1);
        next_cycle();
        @(negedge clk);
        chk("unlock_dbg_gnt", dbg_gnt, 1);
        next_cycle();
        @(negedge clk);
        chk("unlock_cpu_gnt2", cpu_gnt, 1);
        next_cycle();

        // reset lands before the read data comes back
        set_dbg(0, 0, 0, 8'h00, 8'h00);
        set_cpu(1, 0, 8'h10, 8'h00);
        @(negedge clk);
        chk("mid_cpu_gnt", cpu_gnt, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_gnt_gated", cpu_gnt, 0);
        chk("mid_mem_en", mem_en, 0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            set_cpu(1, 0, 8'h10, 8'h00);
            set_dbg(1, 0, 0, 8'h20, 8'h00);
            @(negedge clk);
            chk("inrst_gnt", {cpu_gnt, dbg_gnt, mem_en}, 0);
            chk("inrst_rvalid", {cpu_rvalid, dbg_rvalid}, 0);
            chk("inrst_rdata", {cpu_rdata, dbg_rdata}, 0);
        end
        next_cycle();
        rst = 1'b1;
        set_cpu(0, 0, 8'h00, 8'h00);
        set_dbg(0, 0, 0, 8'h00, 8'h00);
        @(negedge clk);
        chk("post_rst_rvalid", cpu_rvalid, 0);
        next_cycle();
        set_cpu(1, 0, 8'h10, 8'h00);
        set_dbg(1, 0, 0, 8'h20, 8'h00);
        @(negedge clk);
        chk("post_rst_cpu_first", cpu_gnt, 1);
        next_cycle();
        set_cpu(0, 0, 8'h00, 8'h00);
        set_dbg(0, 0, 0, 8'h00, 8'h00);
        @(negedge clk);
        chk("post_rst_rdata", cpu_rdata, 8'hB5);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
